palette_loader: RTL
===================

// Module: palette_loader
// PURPOSE
//  Write side of the 8-entry x 24-bit colour palette BRAM (port A: clka/ena/wea/addra/dina).
//  Accepts a byte stream over valid/ready (R,G,B per entry, entry 0 first) and assembles 24-bit words.
//  Writes the full palette into the BRAM, then pulses done. The colour lookup block reads the same palette.
//  Sits between the host/UART byte source and the palette BRAM write port.
// PARAMETERS
//  ADDR_W    3     palette address width; NUM_ENTRIES = 2**ADDR_W
//  DATA_W    24    palette word width; must equal 3*BYTE_W
//  BYTE_W    8     input byte width
//  TIMEOUT   1023  max idle cycles in LOAD between accepted bytes before abort (>=1)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request to begin a full palette load; ignored unless IDLE
//  abort      in   1       synchronous abort; returns to IDLE, no further BRAM writes
//  in_valid   in   1       byte source has data
//  in_byte    in   BYTE_W  byte data; order R,G,B
//  in_ready   out  1       loader accepts in_byte this cycle
//  bram_en    out  1       to BRAM ena
//  bram_we    out  1       to BRAM wea
//  bram_addr  out  ADDR_W  to BRAM addra
//  bram_din   out  DATA_W  to BRAM dina
//  busy       out  1       high in any state other than IDLE
//  done       out  1       1-cycle pulse after the last entry is written
//  err        out  1       1-cycle pulse on timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready, bram_en, bram_we, busy, done, err = 0;
//   bram_addr = 0; bram_din = 0; entry counter, byte counter, timeout counter = 0.
//  States: IDLE, LOAD, WRITE, FINISH.
//  IDLE:   start=1 -> LOAD; entry=0, byte_cnt=0, tmo=0. Other inputs ignored.
//  LOAD:   in_ready=1 (combinational from state). Byte accepted when in_valid & in_ready.
//          byte_cnt 0 -> din[23:16], 1 -> din[15:8], 2 -> din[7:0].
//          Third accept -> WRITE next cycle; byte_cnt returns to 0.
//          tmo resets to 0 on every accept, else increments;
//          tmo==TIMEOUT-1 with no accept -> IDLE, err=1 for one cycle, no write.
//  WRITE:  exactly one cycle; bram_en=1, bram_we=1, bram_addr=entry, bram_din=assembled word;
//          in_ready=0. Next state: entry==NUM_ENTRIES-1 -> FINISH, else entry+1 and LOAD, tmo=0.
//  FINISH: done=1 for one cycle -> IDLE. bram_en/we=0.
//  bram_en and bram_we are only ever high in WRITE. Both are registered outputs.
//  Latency: third byte accepted at edge N -> write strobe visible cycle N+1.
//   Full load is >=32 cycles (8 x (3 accept + 1 write)); done follows the last write by 1 cycle.
//  abort: highest priority after reset; any state -> IDLE next cycle.
//   If it arrives in the WRITE cycle, that write still completes; no done, no err.
//  start while busy: ignored, no restart.
//  start and abort same cycle in IDLE: abort wins, stay IDLE.
//  entry counter never wraps past NUM_ENTRIES-1; partial loads leave untouched entries unchanged.
//  rst_n asserted mid-load: immediate IDLE, write strobe drops asynchronously.
// STRUCTURE
//  palette_pkg: state encoding constants (IDLE/LOAD/WRITE/FINISH), ADDR_W/DATA_W/BYTE_W defaults,
//   NUM_ENTRIES. The palette lookup block shares these.
//  Sub-module rgb_byte_packer: 3-byte shift/assemble register with byte_cnt, load/clear inputs,
//   and a word_ready output. FSM, timeout counter and entry counter stay in palette_loader.
// TESTING
//  1 Reset: rst_n=0 mid-LOAD -> all outputs 0 immediately; after release busy=0, in_ready=0.
//  2 Full load, back-to-back valid: 24 bytes 0x00..0x17 -> 8 writes;
//     addr 0 din 0x000102 ... addr 7 din 0x151617; done pulse 1 cycle after addr-7 write; busy=0 next.
//  3 Gapped valid (random 0-5 idle cycles between bytes, TIMEOUT=16) -> same 8 words, no err;
//     readback via BRAM port matches.
//  4 Timeout: TIMEOUT=8, supply 4 bytes then stall -> 1 write (addr 0); err pulses at the
//     8th idle cycle; state IDLE; no done.
//  5 Abort: abort in same cycle as addr-3 write -> addr 3 written, no further writes,
//     no done/err, busy=0 next cycle.
//  6 start while busy and start+abort in IDLE -> no restart and no state change;
//     entry order and write count unaffected.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared definitions for the colour palette blocks (loader and lookup).
// Holds the default geometry of the palette BRAM and the loader state encoding.
package palette_pkg;

  localparam int DEF_ADDR_W      = 3;
  localparam int DEF_DATA_W      = 24;
  localparam int DEF_BYTE_W      = 8;
  localparam int DEF_NUM_ENTRIES = 2 ** DEF_ADDR_W;
  localparam int BYTES_PER_WORD  = 3;    // R, G, B

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/rgb_byte_packer.sv
// Assembles three consecutive bytes (R, G, B) into one palette word, R in the MSBs.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      drop any partial word and restart at the R slot (wins over load_i)
//   load_i       accept byte_i into the current slot
//   byte_i       incoming byte
//   word_o       assembled word including the byte being loaded this cycle
//   word_ready_o high in the cycle the third byte of a word is loaded
module rgb_byte_packer
  import palette_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_ready_o
);

  localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (load_i) begin
      // Slot 0 lands in the top byte, slot 2 in the bottom byte.
      for (int s = 0; s < BYTES_PER_WORD; s++) begin
        if (byte_cnt_q == 2'(s)) begin
          word_d[DATA_W-1-s*BYTE_W -: BYTE_W] = byte_i;
        end
      end
      byte_cnt_d = (byte_cnt_q == LAST_SLOT) ? 2'd0 : byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // Forward the next-state word so the caller can capture a complete word
  // on the same edge that accepts the blue byte.
  assign word_o       = word_d;
  assign word_ready_o = load_i && !clear_i && (byte_cnt_q == LAST_SLOT);

endmodule

// File: rtl/palette_loader.sv
// Loads the full colour palette into the BRAM write port from a byte stream.
// Bytes arrive over valid/ready as R,G,B per entry, entry 0 first. Each
// completed entry is written in a single WRITE cycle; after the last entry a
// one-cycle done pulse is issued. An idle gap of TIMEOUT cycles while waiting
// for a byte aborts the load with a one-cycle err pulse.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  begin a load (only honoured in IDLE)
//   abort_i                  return to IDLE; a write already on the bus completes
//   in_valid_i/in_byte_i     byte source; in_ready_o is the accept handshake
//   bram_en_o/bram_we_o      registered BRAM enables, high only in WRITE
//   bram_addr_o/bram_din_o   registered BRAM address and data
//   busy_o                   high whenever not IDLE
//   done_o                   one-cycle pulse after the last entry write
//   err_o                    one-cycle pulse on idle timeout
module palette_loader
  import palette_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BYTE_W  = DEF_BYTE_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  input  logic [BYTE_W-1:0] in_byte_i,
  output logic              in_ready_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int              TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ENT = ADDR_W'((2 ** ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] entry_q, entry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bram_en_q, bram_en_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;

  logic              accept;
  logic              tmo_expire;
  logic              pk_clear, pk_load;
  logic [DATA_W-1:0] pk_word;
  logic              pk_word_ready;

  assign accept     = (state_q == ST_LOAD) && in_valid_i;
  assign tmo_expire = (state_q == ST_LOAD) && !in_valid_i && (tmo_q == TMO_LAST);

  rgb_byte_packer #(
    .BYTE_W(BYTE_W),
    .DATA_W(DATA_W)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (pk_clear),
    .load_i      (pk_load),
    .byte_i      (in_byte_i),
    .word_o      (pk_word),
    .word_ready_o(pk_word_ready)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    tmo_d       = tmo_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    pk_clear    = 1'b0;
    pk_load     = 1'b0;

    if (abort_i) begin
      // A strobe already on the bus this cycle still lands; nothing new is issued.
      state_d  = ST_IDLE;
      tmo_d    = '0;
      pk_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d  = ST_LOAD;
            entry_d  = '0;
            tmo_d    = '0;
            pk_clear = 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            pk_load = 1'b1;
            tmo_d   = '0;
            if (pk_word_ready) begin
              // Strobe is registered so it appears the cycle after the blue byte.
              state_d     = ST_WRITE;
              bram_en_d   = 1'b1;
              bram_addr_d = entry_q;
              bram_din_d  = pk_word;
            end
          end else if (tmo_expire) begin
            state_d  = ST_IDLE;
            tmo_d    = '0;
            pk_clear = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_WRITE: begin
          tmo_d = '0;
          if (entry_q == LAST_ENT) begin
            state_d = ST_FINISH;
          end else begin
            entry_d = entry_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      tmo_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      tmo_q       <= tmo_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign in_ready_o  = (state_q == ST_LOAD);
  assign bram_en_o   = bram_en_q;
  assign bram_we_o   = bram_en_q;
  assign bram_addr_o = bram_addr_q;
  assign bram_din_o  = bram_din_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_FINISH);
  assign err_o       = tmo_expire && !abort_i;

endmodule
